// File: rtl/rs_pkg.sv
// rs_pkg: shared tag width, dispatch packet, FU classes and FU instance class map
package rs_pkg;
  localparam int TAG_W = 6;
  localparam int PAYLOAD_W = 16;
  localparam int FU_MAX = 8;
  typedef enum logic [1:0] {ALU, LS, MULT, BRANCH} fu_class_e;
  typedef struct packed {
    logic valid;
    fu_class_e fu_class;
    logic [TAG_W-1:0] dest_tag;
    logic [TAG_W-1:0] src1_tag;
    logic src1_ready;
    logic [TAG_W-1:0] src2_tag;
    logic src2_ready;
    logic [PAYLOAD_W-1:0] payload;
  } rs_in_pkt_t;
  localparam fu_class_e FU_CLASS_MAP [FU_MAX] = '{ALU, ALU, ALU, LS, LS, MULT, MULT, BRANCH};
endpackage

// File: rtl/rs_if.sv
// rs_if: dispatch, CDB, FU-ready and issue signals of the reservation station
interface rs_if import rs_pkg::*; #(
  parameter int RS_DEPTH = 16,
  parameter int DISPATCH_W = 3,
  parameter int CDB_W = 3,
  parameter int FU_NUM = 8
) ();
  localparam int CW = $clog2(RS_DEPTH) + 1;
  logic squash;
  rs_in_pkt_t [DISPATCH_W-1:0] rs_in;
  logic [CDB_W-1:0] cdb_valid;
  logic [CDB_W-1:0][TAG_W-1:0] cdb_tag;
  logic [FU_NUM-1:0] fu_ready;
  logic [FU_NUM-1:0] issue_valid;
  rs_in_pkt_t [FU_NUM-1:0] issue_pkt;
  logic [DISPATCH_W-1:0] struct_stall;
  logic [CW-1:0] free_cnt;
  modport master (output squash, rs_in, cdb_valid, cdb_tag, fu_ready,
                  input issue_valid, issue_pkt, struct_stall, free_cnt);
  modport slave (input squash, rs_in, cdb_valid, cdb_tag, fu_ready,
                 output issue_valid, issue_pkt, struct_stall, free_cnt);
endinterface

// File: rtl/rs_psel.sv
// rs_psel: one-hot grant of the lowest-index set request bit
module rs_psel #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  assign gnt = req & (~req + N'(1));
endmodule

// File: rtl/rs_unified.sv
// rs_unified: unified reservation station; define RS_OLDEST_FIRST_EN for oldest-first selection
module rs_unified import rs_pkg::*; #(
  parameter int RS_DEPTH = 16,
  parameter int DISPATCH_W = 3,
  parameter int CDB_W = 3,
  parameter int FU_NUM = 8
) (
  input logic clock,
  input logic reset_n,
  rs_if.slave bus
);
  localparam int CW = $clog2(RS_DEPTH) + 1;
  logic [RS_DEPTH-1:0] ent_v, elig, alloc, issued;
  rs_in_pkt_t ent [RS_DEPTH];
  rs_in_pkt_t alloc_pkt [RS_DEPTH];
  logic [DISPATCH_W-1:0] acc, stall;
  int lane_rank [DISPATCH_W];
  logic [FU_NUM-1:0][RS_DEPTH-1:0] gnt_all;
  logic [FU_NUM-1:0] iss_v;
  rs_in_pkt_t [FU_NUM-1:0] iss_pkt;
  logic [CW-1:0] n_acc, n_iss;

  function automatic logic hit(input logic [TAG_W-1:0] t, input logic [CDB_W-1:0] v,
                               input logic [CDB_W-1:0][TAG_W-1:0] ct);
    logic h;
    h = 1'b0;
    for (int c = 0; c < CDB_W; c++) if (v[c] && ct[c] == t && t != '0) h = 1'b1;
    return h;
  endfunction

`ifdef RS_OLDEST_FIRST_EN
  logic [CW-1:0] age [RS_DEPTH];
  // saturating age per valid entry, cleared on allocation and squash
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
    else for (int i = 0; i < RS_DEPTH; i++)
      age[i] <= (bus.squash || alloc[i]) ? '0 : (ent_v[i] && age[i] != '1) ? age[i] + CW'(1) : age[i];
  end
`endif

  // entries whose sources were both ready at the start of the cycle
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) elig[i] = ent_v[i] && ent[i].src1_ready && ent[i].src2_ready;
  end

  for (genvar f = 0; f < FU_NUM; f++) begin : g_fu
    logic [RS_DEPTH-1:0] cand, req, gnt, taken_in, taken_out;
    if (f == 0) begin : g_head
      assign taken_in = '0;
    end else begin : g_tail
      assign taken_in = g_fu[f-1].taken_out;
    end
    // eligible entries of this instance's class not already claimed by a lower instance
    always_comb begin
      for (int i = 0; i < RS_DEPTH; i++)
        cand[i] = elig[i] && ent[i].fu_class == FU_CLASS_MAP[f] && !taken_in[i] && bus.fu_ready[f];
    end
`ifdef RS_OLDEST_FIRST_EN
    logic [CW-1:0] max_age;
    // keep only the oldest candidates so the priority selector breaks ties by index
    always_comb begin
      max_age = '0;
      for (int i = 0; i < RS_DEPTH; i++) if (cand[i] && age[i] > max_age) max_age = age[i];
      for (int i = 0; i < RS_DEPTH; i++) req[i] = cand[i] && age[i] == max_age;
    end
`else
    assign req = cand;
`endif
    rs_psel #(.N(RS_DEPTH)) u_psel (.req(req), .gnt(gnt));
    assign taken_out = taken_in | gnt;
    assign gnt_all[f] = gnt;
  end

  // issue packet mux and count of entries leaving this cycle
  always_comb begin
    issued = '0;
    n_iss = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      iss_v[f] = |gnt_all[f];
      iss_pkt[f] = '0;
      issued = issued | gnt_all[f];
      for (int i = 0; i < RS_DEPTH; i++) if (gnt_all[f][i]) iss_pkt[f] = ent[i];
    end
    for (int i = 0; i < RS_DEPTH; i++) n_iss = n_iss + CW'(issued[i]);
  end

  // rank valid lanes; a lane stalls when fewer free entries exist than its rank needs
  always_comb begin
    int rank;
    rank = 0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      lane_rank[l] = rank;
      stall[l] = bus.rs_in[l].valid && int'(bus.free_cnt) <= rank;
      acc[l] = bus.rs_in[l].valid && !stall[l];
      rank = rank + int'(bus.rs_in[l].valid);
    end
  end
  assign bus.struct_stall = stall;

  // place the r-th accepted lane into the r-th lowest free entry, with CDB bypass
  always_comb begin
    int fr;
    fr = 0;
    n_acc = '0;
    for (int l = 0; l < DISPATCH_W; l++) n_acc = n_acc + CW'(acc[l]);
    for (int i = 0; i < RS_DEPTH; i++) begin
      alloc[i] = 1'b0;
      alloc_pkt[i] = '0;
      if (!ent_v[i]) begin
        for (int l = 0; l < DISPATCH_W; l++) if (acc[l] && lane_rank[l] == fr) begin
          alloc[i] = 1'b1;
          alloc_pkt[i] = bus.rs_in[l];
        end
        fr = fr + 1;
      end
      alloc_pkt[i].src1_ready = alloc_pkt[i].src1_ready | hit(alloc_pkt[i].src1_tag, bus.cdb_valid, bus.cdb_tag);
      alloc_pkt[i].src2_ready = alloc_pkt[i].src2_ready | hit(alloc_pkt[i].src2_tag, bus.cdb_valid, bus.cdb_tag);
    end
  end

  // entry storage, wakeup, issue registers and free count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || bus.squash) begin
      ent_v <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
      bus.issue_valid <= '0;
      bus.issue_pkt <= '0;
      bus.free_cnt <= CW'(RS_DEPTH);
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_v[i] <= alloc[i] | (ent_v[i] & ~issued[i]);
        if (alloc[i]) ent[i] <= alloc_pkt[i];
        else begin
          if (hit(ent[i].src1_tag, bus.cdb_valid, bus.cdb_tag)) ent[i].src1_ready <= 1'b1;
          if (hit(ent[i].src2_tag, bus.cdb_valid, bus.cdb_tag)) ent[i].src2_ready <= 1'b1;
        end
      end
      bus.issue_valid <= iss_v;
      bus.issue_pkt <= iss_pkt;
      bus.free_cnt <= bus.free_cnt - n_acc + n_iss;
    end
  end
endmodule

// File: tb/tb_rs_unified.sv
// tb_rs_unified: directed vectors plus a per-cycle behavioural model for rs_unified
module tb_rs_unified;
  import rs_pkg::*;
  localparam int D = 16, DW = 3, CDW = 3, FN = 8;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, passed = 0;
  rs_if #(.RS_DEPTH(D), .DISPATCH_W(DW), .CDB_W(CDW), .FU_NUM(FN)) bus ();
  rs_unified #(.RS_DEPTH(D), .DISPATCH_W(DW), .CDB_W(CDW), .FU_NUM(FN)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic rs_in_pkt_t mk(fu_class_e c, int d, int s1, bit r1, int s2, bit r2, int pl);
    rs_in_pkt_t p;
    p.valid = 1'b1;
    p.fu_class = c;
    p.dest_tag = TAG_W'(d);
    p.src1_tag = TAG_W'(s1);
    p.src1_ready = r1;
    p.src2_tag = TAG_W'(s2);
    p.src2_ready = r2;
    p.payload = PAYLOAD_W'(pl);
    return p;
  endfunction

  task automatic clr();
    bus.squash = 1'b0;
    bus.rs_in = '0;
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // behavioural model: entry list with a free-list queue, selection per FU from the rules
  logic m_v [D];
  rs_in_pkt_t m_e [D];
  int m_age [D];
  logic [FN-1:0] m_iv = '0;
  rs_in_pkt_t m_ip [FN];
  int m_free = D;
  bit m_taken [D];
  int m_q [$];

  function automatic bit cdb_has(logic [TAG_W-1:0] t);
    if (t == 0) return 1'b0;
    for (int c = 0; c < CDW; c++) if (bus.cdb_valid[c] && bus.cdb_tag[c] == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    int best;
    rs_in_pkt_t p;
    if (!reset_n || bus.squash) begin
      for (int i = 0; i < D; i++) begin m_v[i] = 1'b0; m_e[i] = '0; m_age[i] = 0; end
      for (int f = 0; f < FN; f++) m_ip[f] = '0;
      m_iv = '0;
      m_free = D;
    end else begin
      for (int i = 0; i < D; i++) m_taken[i] = 1'b0;
      for (int f = 0; f < FN; f++) begin
        m_iv[f] = 1'b0;
        m_ip[f] = '0;
        best = -1;
        if (bus.fu_ready[f]) for (int i = 0; i < D; i++)
          if (m_v[i] && !m_taken[i] && m_e[i].src1_ready && m_e[i].src2_ready && m_e[i].fu_class == FU_CLASS_MAP[f])
`ifdef RS_OLDEST_FIRST_EN
            if (best < 0 || m_age[i] > m_age[best]) best = i;
`else
            if (best < 0) best = i;
`endif
        if (best >= 0) begin m_taken[best] = 1'b1; m_iv[f] = 1'b1; m_ip[f] = m_e[best]; end
      end
      m_q.delete();
      for (int i = 0; i < D; i++) begin
        if (!m_v[i]) m_q.push_back(i);
        else if (m_taken[i]) m_v[i] = 1'b0;
        else begin
          if (m_age[i] < 2 * D - 1) m_age[i]++;
          if (cdb_has(m_e[i].src1_tag)) m_e[i].src1_ready = 1'b1;
          if (cdb_has(m_e[i].src2_tag)) m_e[i].src2_ready = 1'b1;
        end
      end
      for (int l = 0; l < DW; l++) if (bus.rs_in[l].valid && m_q.size() > 0) begin
        best = m_q.pop_front();
        p = bus.rs_in[l];
        if (cdb_has(p.src1_tag)) p.src1_ready = 1'b1;
        if (cdb_has(p.src2_tag)) p.src2_ready = 1'b1;
        m_v[best] = 1'b1;
        m_e[best] = p;
        m_age[best] = 0;
      end
      m_free = 0;
      for (int i = 0; i < D; i++) if (!m_v[i]) m_free++;
    end
  end

  always @(negedge clock) begin : compare
    int r;
    logic [DW-1:0] exp_st;
    if (reset_n) begin
      r = 0;
      exp_st = '0;
      for (int l = 0; l < DW; l++) if (bus.rs_in[l].valid) begin
        if (m_free < r + 1) exp_st[l] = 1'b1;
        r++;
      end
      chk("struct_stall", bus.struct_stall, exp_st);
      chk("free_cnt", bus.free_cnt, m_free);
      chk("issue_valid", bus.issue_valid, m_iv);
      for (int f = 0; f < FN; f++) if (m_iv[f]) chk($sformatf("issue_pkt[%0d]", f), bus.issue_pkt[f], m_ip[f]);
    end
  end

  initial begin
    clr();
    bus.fu_ready = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset free_cnt", bus.free_cnt, 16);
    chk("reset issue_valid", bus.issue_valid, 0);
    chk("reset issue_pkt0", bus.issue_pkt[0], 0);
    reset_n = 1'b1;
    // three ALU lanes, all ready
    bus.fu_ready = '1;
    for (int l = 0; l < DW; l++) bus.rs_in[l] = mk(ALU, 10 + l, 1, 1, 2, 1, 'h100 + l);
    #1 chk("alu3 stall", bus.struct_stall, 0);
    tick();
    clr();
    chk("alu3 free after dispatch", bus.free_cnt, 13);
    tick();
    chk("alu3 issue_valid", bus.issue_valid[2:0], 3'b111);
    chk("alu3 fu0 payload", bus.issue_pkt[0].payload, 'h100);
    chk("alu3 fu2 payload", bus.issue_pkt[2].payload, 'h102);
    chk("alu3 free restored", bus.free_cnt, 16);
    // fill 15 entries with waiting branches
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < DW; l++) bus.rs_in[l] = mk(BRANCH, 1, 32 + 3 * c + l, 0, 3, 1, 'h200 + 3 * c + l);
      tick();
      clr();
    end
    chk("fill free_cnt", bus.free_cnt, 1);
    for (int l = 0; l < DW; l++) bus.rs_in[l] = mk(ALU, 4, 1, 1, 1, 1, (l == 0) ? 'hBEEF : 'h300 + l);
    #1 chk("one free stall", bus.struct_stall, 3'b110);
    tick();
    clr();
    for (int l = 0; l < DW; l++) bus.rs_in[l] = mk(ALU, 5, 1, 1, 1, 1, 'h400 + l);
    #1 chk("full stall", bus.struct_stall, 3'b111);
    chk("full free_cnt", bus.free_cnt, 0);
    tick();
    clr();
    chk("only free entry issues", bus.issue_pkt[0].payload, 'hBEEF);
    chk("only free entry valid", bus.issue_valid[0], 1'b1);
    // refill, wake three branches, then squash with a dispatch pending
    bus.fu_ready = '0;
    bus.rs_in[0] = mk(ALU, 6, 1, 1, 1, 1, 'h1234);
    tick();
    clr();
    chk("refull free_cnt", bus.free_cnt, 0);
    bus.cdb_valid = 3'b111;
    bus.cdb_tag[0] = 32;
    bus.cdb_tag[1] = 33;
    bus.cdb_tag[2] = 34;
    tick();
    clr();
    bus.squash = 1'b1;
    bus.fu_ready = '1;
    for (int l = 0; l < DW; l++) bus.rs_in[l] = mk(ALU, 7, 1, 1, 1, 1, 'h500 + l);
    tick();
    clr();
    chk("squash issue_valid", bus.issue_valid, 0);
    chk("squash free_cnt", bus.free_cnt, 16);
    tick();
    chk("squash dispatch dropped", bus.issue_valid, 0);
    chk("squash free stays", bus.free_cnt, 16);
    // MULT with CDB bypass; ALU waiting on tag 0 must not wake
    bus.rs_in[0] = mk(MULT, 20, 5, 0, 1, 1, 'h5555);
    bus.rs_in[1] = mk(ALU, 21, 0, 0, 1, 1, 'h0A0A);
    bus.cdb_valid = 3'b011;
    bus.cdb_tag[0] = 0;
    bus.cdb_tag[1] = 5;
    tick();
    clr();
    tick();
    chk("bypass mult issue", bus.issue_valid[5], 1'b1);
    chk("bypass mult payload", bus.issue_pkt[5].payload, 'h5555);
    chk("tag0 no wake", bus.issue_valid[0], 1'b0);
    chk("tag0 entry held", bus.free_cnt, 15);
    bus.squash = 1'b1;
    tick();
    clr();
    // two LS entries, one LS unit ready
    bus.fu_ready = 8'h10;
    bus.rs_in[0] = mk(LS, 22, 1, 1, 1, 1, 'hA1);
    bus.rs_in[1] = mk(LS, 23, 1, 1, 1, 1, 'hA2);
    tick();
    clr();
    tick();
    chk("ls first issue_valid", bus.issue_valid, 8'h10);
    chk("ls first payload", bus.issue_pkt[4].payload, 'hA1);
    tick();
    chk("ls second issue_valid", bus.issue_valid, 8'h10);
    chk("ls second payload", bus.issue_pkt[4].payload, 'hA2);
    tick();
    chk("ls drained", bus.issue_valid, 0);
    // mixed traffic with a mid-cycle asynchronous reset
    for (int n = 0; n < 300; n++) begin
      bus.fu_ready = FN'($urandom);
      bus.squash = ($urandom_range(0, 49) == 0);
      for (int l = 0; l < DW; l++)
        bus.rs_in[l] = $urandom_range(0, 1) ? mk(fu_class_e'($urandom_range(0, 3)), $urandom_range(1, 63),
          $urandom_range(1, 15), 1'($urandom_range(0, 1)), $urandom_range(1, 15), 1'($urandom_range(0, 1)),
          $urandom_range(0, 65535)) : '0;
      for (int c = 0; c < CDW; c++) begin
        bus.cdb_valid[c] = 1'($urandom_range(0, 1));
        bus.cdb_tag[c] = TAG_W'($urandom_range(0, 15));
      end
      tick();
      if (n == 150) begin
        #2 reset_n = 1'b0;
        #1 chk("async reset issue_valid", bus.issue_valid, 0);
        chk("async reset free_cnt", bus.free_cnt, 16);
        chk("async reset issue_pkt0", bus.issue_pkt[0], 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
      end
    end
    clr();
    bus.squash = 1'b1;
    tick();
    clr();
`ifdef RS_OLDEST_FIRST_EN
    // entry 9 allocated before entry 2; the older one must win the single ALU
    bus.fu_ready = '0;
    for (int k = 0; k < 10; k++) begin
      bus.rs_in[k % 3] = (k == 9) ? mk(ALU, 30, 50, 0, 1, 1, 'h9999) : mk(BRANCH, 31, 20 + k, 0, 1, 1, 'h600 + k);
      if (k % 3 == 2 || k == 9) begin tick(); clr(); end
    end
    bus.cdb_valid = 3'b001;
    bus.cdb_tag[0] = 22;
    tick();
    clr();
    bus.fu_ready = 8'h80;
    tick();
    chk("old prep branch issue", bus.issue_pkt[7].payload, 'h602);
    bus.fu_ready = '0;
    bus.rs_in[0] = mk(ALU, 32, 1, 1, 1, 1, 'h2222);
    bus.cdb_valid = 3'b001;
    bus.cdb_tag[0] = 50;
    tick();
    clr();
    bus.fu_ready = 8'h01;
    tick();
    chk("oldest first", bus.issue_pkt[0].payload, 'h9999);
    tick();
    chk("younger next", bus.issue_pkt[0].payload, 'h2222);
    bus.squash = 1'b1;
    tick();
    clr();
`endif
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
